// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN      | normal issue; branch, load-use and memory wait are evaluated
// BR_FLUSH | extra bubble cycles after a taken branch (flush_cnt remaining)
// MEM_WAIT | whole pipe frozen on a data-memory wait; flush_cnt is preserved
//
// A freeze entered from BR_FLUSH keeps flush_cnt non-zero, and that is how
// the release cycle knows to resume the flush sequence. flush_cnt is always
// zero in RUN.
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       ID_opcode,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic [6:0]       EX_opcode,
  input  logic [4:0]       EX_rd,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pipe_freeze,
  output logic             PC_stall,
  output logic             IF_ID_stall,
  output logic             ID_flush,
  output logic             EX_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [FC_W-1:0] FC_INIT = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);
  localparam logic [WC_W-1:0] WC_MAX  = '1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_FLUSH = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [FC_W-1:0] flush_cnt, flush_cnt_nx;
  logic [WC_W-1:0] wait_cnt;

  logic uses_rs1, uses_rs2, load_use, wait_req, in_flush;

  // Hazard detection: which source registers the ID instruction actually reads.
  always_comb begin
    uses_rs1 = (ID_opcode == OP_IMM) || (ID_opcode == OP_REG) || (ID_opcode == OP_BR) ||
               (ID_opcode == OP_LD)  || (ID_opcode == OP_ST);
    uses_rs2 = (ID_opcode == OP_REG) || (ID_opcode == OP_BR) || (ID_opcode == OP_ST);
    load_use = (EX_opcode == OP_LD) && (EX_rd != 5'd0) &&
               ((uses_rs1 && (EX_rd == ID_rs1)) || (uses_rs2 && (EX_rd == ID_rs2)));
    wait_req = mem_req && !mem_ready;
    in_flush = (state == BR_FLUSH) || ((state == MEM_WAIT) && (flush_cnt != '0));
  end

  // Next-state and control outputs, in priority order: wait, flush, branch, load-use.
  always_comb begin
    state_nx     = RUN;
    flush_cnt_nx = flush_cnt;
    pipe_freeze  = 1'b0;
    PC_stall     = 1'b0;
    IF_ID_stall  = 1'b0;
    ID_flush     = 1'b0;
    EX_flush     = 1'b0;

    if (wait_req) begin
      pipe_freeze = 1'b1;
      PC_stall    = 1'b1;
      IF_ID_stall = 1'b1;
      state_nx    = MEM_WAIT;
    end else if (in_flush) begin
      ID_flush     = 1'b1;
      EX_flush     = 1'b1;
      flush_cnt_nx = flush_cnt - FC_ONE;
      state_nx     = (flush_cnt == FC_ONE) ? RUN : BR_FLUSH;
    end else if (branch_taken) begin
      ID_flush = 1'b1;
      EX_flush = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_nx     = BR_FLUSH;
        flush_cnt_nx = FC_INIT;
      end
    end else if (load_use) begin
      PC_stall    = 1'b1;
      IF_ID_stall = 1'b1;
      EX_flush    = 1'b1;
    end

    // While in reset the pipe is filled with bubbles and nothing holds.
    if (rst) begin
      pipe_freeze = 1'b0;
      PC_stall    = 1'b0;
      IF_ID_stall = 1'b0;
      ID_flush    = 1'b1;
      EX_flush    = 1'b1;
    end
  end

  // State and flush counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      flush_cnt <= '0;
    end else begin
      state     <= state_nx;
      flush_cnt <= flush_cnt_nx;
    end
  end

  // Memory-wait length tracking; mem_timeout is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (wait_req) begin
      if (wait_cnt != WC_MAX) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (wait_cnt >= WC_LAST) begin
        mem_timeout <= 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  // Saturating count of PC-stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (PC_stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl with FLUSH_CYCLES=3, MEM_TIMEOUT=4, CNT_W=4.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] SAT = '1;

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OPR = 7'b0110011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] JAL = 7'b1101111;

  // exp_ctrl = {pipe_freeze, PC_stall, IF_ID_stall, ID_flush, EX_flush}
  typedef struct {
    string      name;
    logic       rst;
    logic [6:0] id_op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] ex_op;
    logic [4:0] ex_rd;
    logic       br;
    logic       mreq;
    logic       mrdy;
    logic [4:0] exp_ctrl;
    logic       exp_to;
  } vec_t;

  logic             clk, rst;
  logic [6:0]       ID_opcode, EX_opcode;
  logic [4:0]       ID_rs1, ID_rs2, EX_rd;
  logic             branch_taken, mem_req, mem_ready;
  logic             pipe_freeze, PC_stall, IF_ID_stall, ID_flush, EX_flush, mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  int tests = 0;
  int fails = 0;
  logic [CNT_W-1:0] exp_stall = '0;
  vec_t tbl[$];
  vec_t sb[$];

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ID_opcode(ID_opcode), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .EX_opcode(EX_opcode), .EX_rd(EX_rd),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pipe_freeze(pipe_freeze), .PC_stall(PC_stall), .IF_ID_stall(IF_ID_stall),
    .ID_flush(ID_flush), .EX_flush(EX_flush),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string n, logic r, logic [6:0] io, logic [4:0] a, logic [4:0] b,
                              logic [6:0] eo, logic [4:0] d, logic bt, logic mq, logic mr,
                              logic [4:0] c, logic to);
    vec_t v;
    v.name = n; v.rst = r; v.id_op = io; v.rs1 = a; v.rs2 = b; v.ex_op = eo; v.ex_rd = d;
    v.br = bt; v.mreq = mq; v.mrdy = mr; v.exp_ctrl = c; v.exp_to = to;
    return v;
  endfunction

  function automatic vec_t idle(string n, logic to);
    return mk(n, 1'b0, OPI, 5'd0, 5'd0, OPI, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, to);
  endfunction

  task automatic check_out();
    vec_t e;
    logic [4:0] act;
    e = sb.pop_front();
    act = {pipe_freeze, PC_stall, IF_ID_stall, ID_flush, EX_flush};
    tests++;
    if (act !== e.exp_ctrl) begin
      fails++;
      $display("FAIL %s ctrl: got %b expected %b", e.name, act, e.exp_ctrl);
    end
    if (!e.rst) begin
      tests++;
      if (mem_timeout !== e.exp_to) begin
        fails++;
        $display("FAIL %s mem_timeout: got %b expected %b", e.name, mem_timeout, e.exp_to);
      end
      tests++;
      if (stall_cycles !== exp_stall) begin
        fails++;
        $display("FAIL %s stall_cycles: got %0d expected %0d", e.name, stall_cycles, exp_stall);
      end
    end
    if (e.rst) exp_stall = '0;
    else if (e.exp_ctrl[3] && exp_stall != SAT) exp_stall = exp_stall + 1'b1;
  endtask

  task automatic step(vec_t v);
    rst = v.rst; ID_opcode = v.id_op; ID_rs1 = v.rs1; ID_rs2 = v.rs2;
    EX_opcode = v.ex_op; EX_rd = v.ex_rd;
    branch_taken = v.br; mem_req = v.mreq; mem_ready = v.mrdy;
    sb.push_back(v);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ID_opcode = OPI; ID_rs1 = '0; ID_rs2 = '0; EX_opcode = OPI; EX_rd = '0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;

    tbl.push_back(mk("reset", 1, OPI, 0, 0, OPI, 0, 0, 0, 0, 5'b00011, 0));
    tbl.push_back(idle("after_reset", 0));
    tbl.push_back(mk("lu_add_rs1", 0, OPR, 5, 1, LD, 5, 0, 0, 0, 5'b01101, 0));
    tbl.push_back(idle("lu_cleared", 0));
    tbl.push_back(mk("lw_x0", 0, OPR, 0, 0, LD, 0, 0, 0, 0, 5'b00000, 0));
    tbl.push_back(mk("jal_no_src", 0, JAL, 5, 5, LD, 5, 0, 0, 0, 5'b00000, 0));
    tbl.push_back(mk("lu_store_rs2", 0, ST, 1, 7, LD, 7, 0, 0, 0, 5'b01101, 0));
    tbl.push_back(mk("opimm_rs2_unused", 0, OPI, 2, 9, LD, 9, 0, 0, 0, 5'b00000, 0));
    tbl.push_back(mk("lu_branch_rs1", 0, BR, 3, 4, LD, 3, 0, 0, 0, 5'b01101, 0));
    tbl.push_back(mk("ex_not_load", 0, OPR, 6, 6, OPR, 6, 0, 0, 0, 5'b00000, 0));
    tbl.push_back(mk("br_taken", 0, OPI, 0, 0, BR, 0, 1, 0, 0, 5'b00011, 0));
    tbl.push_back(mk("br_flush2_lu_ign", 0, OPR, 5, 1, LD, 5, 0, 0, 0, 5'b00011, 0));
    tbl.push_back(mk("br_flush3_lu_ign", 0, OPR, 5, 1, LD, 5, 0, 0, 0, 5'b00011, 0));
    tbl.push_back(idle("br_done", 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk($sformatf("freeze_br_%0d", i), 0, OPI, 0, 0, BR, 0, 1, 1, 0, 5'b11100, (i == 4)));
    tbl.push_back(mk("release_br", 0, OPI, 0, 0, BR, 0, 1, 1, 1, 5'b00011, 1));
    tbl.push_back(mk("freeze_in_flush", 0, OPI, 0, 0, OPI, 0, 0, 1, 0, 5'b11100, 1));
    tbl.push_back(idle("resume_flush2", 1));
    tbl[$].exp_ctrl = 5'b00011;
    tbl.push_back(idle("resume_flush3", 1));
    tbl[$].exp_ctrl = 5'b00011;
    tbl.push_back(idle("flush_over", 1));
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk($sformatf("sat_lu_%0d", i), 0, OPR, 5, 1, LD, 5, 0, 0, 0, 5'b01101, 1));
    tbl.push_back(idle("sat_hold", 1));
    tbl.push_back(mk("br_then_rst", 0, OPI, 0, 0, BR, 0, 1, 0, 0, 5'b00011, 1));
    tbl.push_back(mk("rst_in_flush", 1, OPI, 0, 0, OPI, 0, 0, 0, 0, 5'b00011, 0));
    tbl.push_back(idle("no_residual_1", 0));
    tbl.push_back(idle("no_residual_2", 0));
    tbl.push_back(mk("wait_then_rst", 0, OPI, 0, 0, OPI, 0, 0, 1, 0, 5'b11100, 0));
    tbl.push_back(mk("rst_in_wait", 1, OPI, 0, 0, OPI, 0, 0, 1, 0, 5'b00011, 0));
    tbl.push_back(idle("after_wait_rst", 0));

    @(posedge clk);
    #1;
    foreach (tbl[i]) step(tbl[i]);

    // Long wait: timeout sets after the 4th wait cycle and survives release.
    for (int i = 1; i <= 10; i++)
      step(mk($sformatf("long_wait_%0d", i), 0, OPI, 0, 0, OPI, 0, 0, 1, 0, 5'b11100, (i >= 5)));
    step(idle("timeout_sticky_1", 1));
    step(idle("timeout_sticky_2", 1));
    step(mk("timeout_rst", 1, OPI, 0, 0, OPI, 0, 0, 0, 0, 5'b00011, 0));
    step(idle("timeout_cleared", 0));

    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
